// File: rtl/io_ram_pkg.sv
// Shared definitions for the IO-module RAM address port arbiter.
//   - Requester indices (Decompressor, FileLoader, CNN, LayerInput).
//   - Arbiter state enum.
//   - Load/Image/Layer select codes per requester and a grant-to-select helper.
package io_ram_pkg;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned REQ_DECOMP = 0;
    localparam int unsigned REQ_FILE   = 1;
    localparam int unsigned REQ_CNN    = 2;
    localparam int unsigned REQ_LAYER  = 3;

    typedef enum logic [1:0] {
        StIdle,
        StBurst,
        StTurn
    } arb_state_e;

    // Select codes as {Load, Image, Layer}.
    localparam logic [2:0] SEL_NONE   = 3'b000;
    localparam logic [2:0] SEL_DECOMP = 3'b100;
    localparam logic [2:0] SEL_FILE   = 3'b110;
    localparam logic [2:0] SEL_CNN    = 3'b011;
    localparam logic [2:0] SEL_LAYER  = 3'b001;

    function automatic logic [2:0] sel_of_grant(input logic [3:0] grant);
        logic [2:0] sel;
        case (grant)
            4'b0001: sel = SEL_DECOMP;
            4'b0010: sel = SEL_FILE;
            4'b0100: sel = SEL_CNN;
            4'b1000: sel = SEL_LAYER;
            default: sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [1:0] grant_idx(input logic [3:0] grant);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bus between the four RAM-port requesters and the arbiter.
//   req/last/addr : requester side (master drives)
//   grant, load/image/layer, address_to_ram, preempt : arbiter side (slave drives)
//   grant_count/busy : only present when ARB_STATS_EN is defined
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [3:0]          req;
    logic [3:0]          last;
    logic [4*ADDR_W-1:0] addr;
    logic [3:0]          grant;
    logic                load;
    logic                image;
    logic                layer;
    logic [ADDR_W-1:0]   address_to_ram;
    logic                preempt;
`ifdef ARB_STATS_EN
    logic [4*16-1:0]     grant_count;
    logic                busy;

    modport master (
        output req, last, addr,
        input  grant, load, image, layer, address_to_ram, preempt, grant_count, busy
    );
    modport slave (
        input  req, last, addr,
        output grant, load, image, layer, address_to_ram, preempt, grant_count, busy
    );
`else
    modport master (
        output req, last, addr,
        input  grant, load, image, layer, address_to_ram, preempt
    );
    modport slave (
        input  req, last, addr,
        output grant, load, image, layer, address_to_ram, preempt
    );
`endif
endinterface

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker.
//   req_i   : request vector
//   ptr_i   : index where the search starts (wraps 3 -> 0)
//   gnt_o   : one-hot winner, lowest index at/after ptr_i
//   valid_o : any request present
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic       valid_o
);
    logic [1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        gnt_o = 4'b0000;
        idx   = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_i + 2'(k);
            if (req_i[idx]) gnt_o = 4'b0001 << idx;
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared RAM address port.
// Grants one of four requesters with burst lock, drives the Load/Image/Layer select
// code and the muxed address, and inserts one dead turnaround cycle after each burst.
//   clk_i  : clock, all state on rising edge
//   rst_i  : synchronous active-high reset
//   bus_io : slave side of ram_port_arbiter_if (req/last/addr in; grant, select,
//            address_to_ram, preempt out)
// Optional: define ARB_STATS_EN to add per-requester grant counters and busy.
module ram_port_arbiter
    import io_ram_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MAX_BURST = 64,
    parameter int unsigned CNT_W     = 7
) (
    input logic                 clk_i,
    input logic                 rst_i,
    ram_port_arbiter_if.slave   bus_io
);
    // Counter value on the last permitted cycle of a burst.
    localparam logic [CNT_W-1:0] LimitCnt = CNT_W'((MAX_BURST == 0) ? 0 : MAX_BURST - 1);

    arb_state_e       state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic [3:0]       pick_gnt;
    logic             pick_valid;
    logic             own_req;
    logic             own_last;
    logic             at_limit;
    logic             issue;

    rr_pick4 u_pick (
        .req_i   (bus_io.req),
        .ptr_i   (ptr_q),
        .gnt_o   (pick_gnt),
        .valid_o (pick_valid)
    );

    assign own_req  = |(grant_q & bus_io.req);
    assign own_last = |(grant_q & bus_io.last);
    assign at_limit = (MAX_BURST != 0) && (cnt_q == LimitCnt);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            StIdle, StTurn: begin
                if (pick_valid) begin
                    grant_d = pick_gnt;
                    ptr_d   = grant_idx(pick_gnt) + 2'd1;
                    cnt_d   = '0;
                    state_d = StBurst;
                    issue   = 1'b1;
                end else begin
                    grant_d = 4'b0000;
                    state_d = StIdle;
                end
            end
            StBurst: begin
                if (!own_req || own_last || at_limit) begin
                    state_d   = StTurn;
                    grant_d   = 4'b0000;
                    // Only a release caused purely by the burst limit counts as forced.
                    preempt_d = at_limit && own_req && !own_last;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            grant_q   <= 4'b0000;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    logic [ADDR_W-1:0] addr_mux;

    always_comb begin
        addr_mux = '0;
        for (int i = 0; i < 4; i++) begin
            if (grant_q[i]) addr_mux = bus_io.addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign bus_io.grant                              = grant_q;
    assign {bus_io.load, bus_io.image, bus_io.layer} = sel_of_grant(grant_q);
    assign bus_io.address_to_ram                     = addr_mux;
    assign bus_io.preempt                            = preempt_q;

`ifdef ARB_STATS_EN
    logic [3:0][15:0] gcnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gcnt_q <= '0;
        end else if (issue) begin
            for (int i = 0; i < 4; i++) begin
                if (pick_gnt[i] && gcnt_q[i] != 16'hFFFF) gcnt_q[i] <= gcnt_q[i] + 16'd1;
            end
        end
    end

    assign bus_io.grant_count = gcnt_q;
    assign bus_io.busy        = (state_q != StIdle);
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(16)) bus ();

    ram_port_arbiter #(
        .ADDR_W    (16),
        .MAX_BURST (MAXB),
        .CNT_W     (7)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the port, how many accesses it has made, where the
    // round-robin search starts, and whether we are in the dead cycle after a burst.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    bit m_preempt = 1'b0;
    bit m_turn    = 1'b0;
    int m_cnt [4] = '{0, 0, 0, 0};

    function automatic int rr_winner(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner   <= -1;
            m_held    <= 0;
            m_ptr     <= 0;
            m_preempt <= 1'b0;
            m_turn    <= 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
        end else if (m_owner >= 0) begin
            if (!bus.req[m_owner] || bus.last[m_owner] || (MAXB != 0 && m_held + 1 >= MAXB)) begin
                m_owner   <= -1;
                m_turn    <= 1'b1;
                m_preempt <= (MAXB != 0 && m_held + 1 >= MAXB) && bus.req[m_owner]
                             && !bus.last[m_owner];
            end else begin
                m_held    <= m_held + 1;
                m_preempt <= 1'b0;
                m_turn    <= 1'b0;
            end
        end else begin
            m_preempt <= 1'b0;
            m_turn    <= 1'b0;
            if (rr_winner(bus.req, m_ptr) >= 0) begin
                m_owner <= rr_winner(bus.req, m_ptr);
                m_held  <= 0;
                m_ptr   <= (rr_winner(bus.req, m_ptr) + 1) % 4;
                if (m_cnt[rr_winner(bus.req, m_ptr)] < 65535)
                    m_cnt[rr_winner(bus.req, m_ptr)] <= m_cnt[rr_winner(bus.req, m_ptr)] + 1;
            end
        end
    end

    function automatic logic [3:0] exp_grant();
        return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    endfunction

    function automatic logic [2:0] exp_sel();
        case (m_owner)
            0:       return 3'b100;
            1:       return 3'b110;
            2:       return 3'b011;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [15:0] exp_addr();
        return (m_owner >= 0) ? bus.addr[m_owner*16 +: 16] : 16'h0000;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("grant", 64'(bus.grant), 64'(exp_grant()));
            check("select", 64'({bus.load, bus.image, bus.layer}), 64'(exp_sel()));
            check("address", 64'(bus.address_to_ram), 64'(exp_addr()));
            check("preempt", 64'(bus.preempt), 64'(m_preempt));
`ifdef ARB_STATS_EN
            check("busy", 64'(bus.busy), 64'((m_owner >= 0) || m_turn));
            for (int i = 0; i < 4; i++)
                check("grant_count", 64'(bus.grant_count[i*16 +: 16]), 64'(m_cnt[i]));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp3 [9] = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [3:0] exp4 [6] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4};
    logic       exp4p [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp5 [4] = '{4'h8, 4'h8, 4'h0, 4'h1};
    // {req, last} per cycle: includes a request withdrawn before it could be granted.
    logic [7:0] mix [16] = '{8'h10, 8'h30, 8'h10, 8'h10, 8'h11, 8'h00, 8'h64, 8'h60,
                             8'h60, 8'h60, 8'h60, 8'h62, 8'h40, 8'h00, 8'hF0, 8'h00};

    initial begin
        bus.req  = 4'hF;
        bus.last = 4'h0;
        bus.addr = {16'hDDDD, 16'hCCCC, 16'h1234, 16'hAAAA};
        rst      = 1'b1;

        // Reset held with all requests active: nothing may be granted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_en = 1'b1;
            check("rst_grant", 64'(bus.grant), 64'h0);
            check("rst_select", 64'({bus.load, bus.image, bus.layer}), 64'h0);
            check("rst_address", 64'(bus.address_to_ram), 64'h0);
        end
        rst     = 1'b0;
        bus.req = 4'b0010;

        // FileLoader burst of three accesses.
        for (int a = 1; a <= 3; a++) begin
            tick();
            check("t2_grant", 64'(bus.grant), 64'h2);
            check("t2_select", 64'({bus.load, bus.image, bus.layer}), 64'h6);
            check("t2_address", 64'(bus.address_to_ram), 64'h1234);
            if (a == 3) bus.last = 4'b0010;
        end
        tick();
        check("t2_turn", 64'(bus.grant), 64'h0);
        bus.req  = 4'h0;
        bus.last = 4'h0;
        tick();
        tick();

        // Round-robin order from pointer 0 with single-access bursts.
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        bus.req  = 4'hF;
        bus.last = 4'hF;
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t3_order", 64'(bus.grant), 64'(exp3[i]));
        end
        bus.req  = 4'h0;
        bus.last = 4'h0;
        repeat (3) tick();

        // Forced release after MAX_BURST cycles, then regrant.
        bus.req = 4'b0100;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t4_grant", 64'(bus.grant), 64'(exp4[i]));
            check("t4_preempt", 64'(bus.preempt), 64'(exp4p[i]));
        end
        bus.req = 4'h0;
        repeat (3) tick();

        // LayerInput withdraws in its second cycle while Decompressor waits.
        bus.req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_grant", 64'(bus.grant), 64'(exp5[i]));
            if (i == 1) bus.req = 4'b0001;
        end
        bus.req = 4'h0;
        repeat (3) tick();

        // Reset in the middle of a burst.
        bus.req = 4'b0100;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("t6_rst_grant", 64'(bus.grant), 64'h0);
        rst     = 1'b0;
        bus.req = 4'h0;
        tick();

        // Mixed vectors, checked by the model only.
        for (int i = 0; i < 16; i++) begin
            bus.req  = mix[i][7:4];
            bus.last = mix[i][3:0];
            tick();
        end
        bus.req  = 4'h0;
        bus.last = 4'h0;
        repeat (3) tick();

`ifdef ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        bus.req  = 4'b0010;
        bus.last = 4'b0010;
        repeat (10) tick();
        bus.req  = 4'h0;
        bus.last = 4'h0;
        tick();
        check("stats_count", 64'(bus.grant_count), {16'd0, 16'd0, 16'd5, 16'd0});
        rst = 1'b1;
        tick();
        check("stats_clear", 64'(bus.grant_count), 64'h0);
        rst = 1'b0;
        tick();
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
